// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Source end of the VGA pixel stream. It generates the raster position
// (hcount/vcount), the sync pulses (hsync/vsync) and the blanking flags
// (hblnk/vblnk) for one pixel per clock. rgb is held at zero so that the
// downstream draw stages (draw_bg, draw_menu, ...) can paint over it.
// It also emits a frame-start pulse and a wrapping frame counter for
// animation and menu logic.
//
// Ports:
//   clk          in   1    pixel clock
//   rst          in   1    synchronous, active-high reset
//   hcount       out  11   horizontal pixel position
//   vcount       out  11   vertical line position
//   hsync        out  1    horizontal sync, active level = SYNC_POL
//   vsync        out  1    vertical sync, active level = SYNC_POL
//   hblnk        out  1    high outside the visible columns
//   vblnk        out  1    high outside the visible lines
//   rgb          out  12   pixel colour, always 12'h000
//   frame_start  out  1    one-cycle pulse when the stream wraps to (0,0)
//   frame_cnt    out  8    frames completed since reset, wraps 255 -> 0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic [11:0] rgb,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The counters are 11 bits wide, so a raster larger than 2048 in either
    // direction cannot be represented.
    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
        end
    endgenerate

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VISIBLE  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VISIBLE  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        h_wrap;
    logic        frame_wrap;

    // Next raster position. Every output is decoded from these next values
    // and registered together, so all fields describe the same pixel on the
    // cycle they appear. vcount only advances on a line wrap, which is why
    // vsync can only change on hcount = 0 cycles.
    always_comb begin
        h_wrap     = (hcount == H_LAST);
        frame_wrap = h_wrap && (vcount == V_LAST);
        h_next     = h_wrap ? 11'd0 : hcount + 11'd1;
        v_next     = vcount;
        if (h_wrap) begin
            v_next = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
        end
    end

    // Output registers. Reset parks the stream at (0,0) with syncs inactive
    // and does not flag a frame start; only a genuine wrap to (0,0) pulses
    // frame_start and advances the frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= 11'd0;
            vcount      <= 11'd0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            rgb         <= 12'h000;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            hcount      <= h_next;
            vcount      <= v_next;
            hblnk       <= (h_next >= H_VISIBLE);
            vblnk       <= (v_next >= V_VISIBLE);
            hsync       <= (h_next >= HS_FIRST && h_next <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_next >= VS_FIRST && v_next <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
            rgb         <= 12'h000;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Self-checking bench for vga_timing_gen. Two instances run side by side on
// a shrunken raster (16 x 10, so a frame is 160 clocks): one with active-high
// syncs and one with active-low syncs. Expected outputs are derived from the
// number of clocks since reset was released, independently of the design.
//
// Raster used here:
//   horizontal: 8 visible, 2 front porch, 3 sync, 3 back porch  (hsync 10..12)
//   vertical  : 6 visible, 1 front porch, 2 sync, 1 back porch  (vsync 7..8)
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HA    = 8;
    localparam int HF    = 2;
    localparam int HS    = 3;
    localparam int HB    = 3;
    localparam int VA    = 6;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [10:0] hcount_a, vcount_a, hcount_b, vcount_b;
    logic        hsync_a, vsync_a, hblnk_a, vblnk_a, fs_a;
    logic        hsync_b, vsync_b, hblnk_b, vblnk_b, fs_b;
    logic [11:0] rgb_a, rgb_b;
    logic [7:0]  cnt_a, cnt_b;

    logic [46:0] obs_a;
    logic [46:0] obs_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit in_rst   = 1'b1;
    int pulses   = 0;

    // Pixel clock.
    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .hcount(hcount_a), .vcount(vcount_a),
        .hsync(hsync_a), .vsync(vsync_a),
        .hblnk(hblnk_a), .vblnk(vblnk_a),
        .rgb(rgb_a), .frame_start(fs_a), .frame_cnt(cnt_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut_neg (
        .clk(clk), .rst(rst),
        .hcount(hcount_b), .vcount(vcount_b),
        .hsync(hsync_b), .vsync(vsync_b),
        .hblnk(hblnk_b), .vblnk(vblnk_b),
        .rgb(rgb_b), .frame_start(fs_b), .frame_cnt(cnt_b)
    );

    assign obs_a = {hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, rgb_a, fs_a, cnt_a};
    assign obs_b = {hcount_b, vcount_b, hsync_b, vsync_b, hblnk_b, vblnk_b, rgb_b, fs_b, cnt_b};

    // Expected packed output for the pixel shown c clocks after reset release.
    function automatic logic [46:0] expVec(input int c, input bit pol, input bit r);
        int   h, v, fr;
        logic hs, vs, hb, vb, fs;
        if (r) begin
            return {11'd0, 11'd0, ~pol, ~pol, 1'b0, 1'b0, 12'h000, 1'b0, 8'd0};
        end
        h  = c % HT;
        v  = (c / HT) % VT;
        fr = c / FRAME;
        hs = (h >= HA + HF && h <= HA + HF + HS - 1) ? pol : ~pol;
        vs = (v >= VA + VF && v <= VA + VF + VS - 1) ? pol : ~pol;
        hb = (h >= HA);
        vb = (v >= VA);
        fs = (c > 0) && (c % FRAME == 0);
        return {11'(h), 11'(v), hs, vs, hb, vb, 12'h000, fs, 8'(fr % 256)};
    endfunction

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [46:0] obs, input logic [46:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cyc=%0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Drives rst for one clock, samples 1 ns after the edge and compares both
    // instances against the cycle-count model.
    task automatic applyStimulus(input bit r);
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            in_rst = 1'b1;
            cyc    = 0;
        end else begin
            in_rst = 1'b0;
            cyc++;
        end
        checkOutput("pix_pos", obs_a, expVec(cyc, 1'b1, in_rst));
        checkOutput("pix_neg", obs_b, expVec(cyc, 1'b0, in_rst));
        if (!r && fs_a) pulses++;
    endtask

    // Directed sequence: reset, 256+ frames, then resets mid-frame and
    // inside both sync windows.
    initial begin
        repeat (3) applyStimulus(1'b1);

        for (int i = 0; i < 256 * FRAME + 20; i++) begin
            applyStimulus(1'b0);
            if (cyc == FRAME)
                checkOutput("first_frame", 47'({fs_a, cnt_a}), 47'({1'b1, 8'd1}));
            if (cyc == 256 * FRAME)
                checkOutput("cnt_wrap", 47'({fs_a, cnt_a}), 47'({1'b1, 8'd0}));
        end
        checkOutput("pulse_count", 47'(pulses), 47'(256));

        // Reset in the visible area (5,3) of a frame where frame_cnt is 1.
        for (int i = 0; i < 400 && cyc != 257 * FRAME + 3 * HT + 5; i++)
            applyStimulus(1'b0);
        checkOutput("pre_rst_pos", 47'({hcount_a, vcount_a, cnt_a}), 47'({11'd5, 11'd3, 8'd1}));
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("resume_pos", 47'({hcount_a, vcount_a}), 47'({11'd1, 11'd0}));

        // Reset at (11,7), inside both hsync and vsync.
        for (int i = 0; i < 400 && cyc < FRAME + 7 * HT + 11; i++)
            applyStimulus(1'b0);
        checkOutput("in_sync", 47'({hsync_a, vsync_a, hsync_b, vsync_b, cnt_a}),
                    47'({4'b1100, 8'd1}));
        applyStimulus(1'b1);
        checkOutput("sync_drop", 47'({hsync_a, vsync_a, hsync_b, vsync_b, cnt_a}),
                    47'({4'b0011, 8'd0}));
        applyStimulus(1'b1);

        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            applyStimulus(1'b0);
            if (cyc == FRAME)
                checkOutput("resume_cnt", 47'({fs_a, cnt_a}), 47'({1'b1, 8'd1}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
